// File: rtl/serial_tx.sv
// Asynchronous-style serial frame transmitter: start bit, DATA_BITS data bits LSB first,
// optional even-parity bit, STOP_BITS stop bits. Bit boundaries follow rising edges of baud_in.
module serial_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_baud_prev;
  logic                 r_tx;
  logic                 r_done;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 w_tick;
  logic                 w_xfer;
  logic                 w_last_bit;
  logic                 w_last_stop;
  logic                 w_tx_nxt;
  logic                 w_ready;

  assign w_tick      = baud_in & ~r_baud_prev;
  assign w_xfer      = valid & w_ready;
  assign w_last_bit  = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; IDLE leaves on a transfer regardless of tick, so a coincident
  // tick is consumed there and ALIGN waits for the following one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (valid) w_state_nxt = S_ALIGN;
      S_ALIGN:  if (w_tick) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_tick && w_last_bit) begin
          w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:   if (w_tick && w_last_stop) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: handshake flags and the next serial line value
  always_comb begin
    w_ready  = (r_state == S_IDLE);
    w_tx_nxt = r_tx;
    if (w_tick) begin
      case (r_state)
        S_IDLE:  w_tx_nxt = 1'b1;
        S_ALIGN: w_tx_nxt = 1'b0;
        S_START: w_tx_nxt = r_shift[0];
        S_DATA: begin
          if (!w_last_bit) begin
            w_tx_nxt = r_shift[0];
          end else if (PARITY_EN != 0) begin
            w_tx_nxt = r_parity;
          end else begin
            w_tx_nxt = 1'b1;
          end
        end
        default: w_tx_nxt = 1'b1;
      endcase
    end
  end

  // Line register, edge detector, counters and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud_prev <= 1'b1;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
    end else begin
      r_baud_prev <= baud_in;
      r_tx        <= w_tx_nxt;
      r_done      <= w_tick && (r_state == S_STOP) && w_last_stop;
      if (w_tick) begin
        case (r_state)
          S_START: begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
          end
          S_DATA: if (!w_last_bit) r_bit_cnt <= r_bit_cnt + 1'b1;
          S_STOP: if (!w_last_stop) r_stop_cnt <= r_stop_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Payload shifter: bit 0 always holds the next data bit to drive
  always_ff @(posedge clk) begin
    if (w_xfer && !reset) begin
      r_shift  <= data;
      r_parity <= ^data;
    end else if (w_tick && ((r_state == S_START) || ((r_state == S_DATA) && !w_last_bit))) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign ready = w_ready;
  assign busy  = ~w_ready;
  assign tx    = r_tx;
  assign done  = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three parameterisations share clock, reset and baud_in;
// sel chooses which instance the frame checks observe and drive.
module tb_serial_tx;

  logic       clk;
  logic       reset;
  logic       baud_in;
  logic [7:0] data;
  logic [2:0] valid_v;
  logic [2:0] w_ready, w_tx, w_busy, w_done;
  logic [1:0] sel;
  logic       tx_s, ready_s, busy_s, done_s;

  int n_pass;
  int n_total;
  int n_fail;
  int div;
  bit baud_run;
  bit baud_rose;
  int waited;
  int cnt;
  bit ok;

  serial_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0)) u_def (
    .clk(clk), .reset(reset), .baud_in(baud_in), .data(data), .valid(valid_v[0]),
    .ready(w_ready[0]), .tx(w_tx[0]), .busy(w_busy[0]), .done(w_done[0]));

  serial_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1)) u_par (
    .clk(clk), .reset(reset), .baud_in(baud_in), .data(data), .valid(valid_v[1]),
    .ready(w_ready[1]), .tx(w_tx[1]), .busy(w_busy[1]), .done(w_done[1]));

  serial_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0)) u_st2 (
    .clk(clk), .reset(reset), .baud_in(baud_in), .data(data), .valid(valid_v[2]),
    .ready(w_ready[2]), .tx(w_tx[2]), .busy(w_busy[2]), .done(w_done[2]));

  assign tx_s    = w_tx[sel];
  assign ready_s = w_ready[sel];
  assign busy_s  = w_busy[sel];
  assign done_s  = w_done[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; baud_in toggles every 4 clocks (8-clock bit period).
  task automatic step();
    @(negedge clk);
    baud_rose = 1'b0;
    if (baud_run) begin
      if (div == 3) begin
        div       = 0;
        baud_in   = ~baud_in;
        baud_rose = baud_in;
      end else begin
        div++;
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    data         = d;
    valid_v[sel] = 1'b1;
    step();
    valid_v[sel] = 1'b0;
  endtask

  task automatic wait_fall(input string tag, output int w, output bit found);
    w = 0;
    while (tx_s !== 1'b0 && w < 64) begin
      step();
      w++;
    end
    found = (tx_s === 1'b0);
    if (!found) chk({tag, "_start_timeout"}, 32'(tx_s), 32'd0);
  endtask

  // exp bit i is the i-th transmitted bit (start bit first); nb bits of 8 clocks each.
  task automatic run_frame(input string tag, input logic [15:0] exp, input int nb,
                           input bit disturb, output int w);
    int  dcnt;
    int  last;
    bit  found;
    wait_fall(tag, w, found);
    if (found) begin
      last = nb * 8;
      dcnt = 0;
      for (int o = 0; o <= last + 1; o++) begin
        if (o > 0) step();
        if (done_s === 1'b1) dcnt++;
        if (o < last && (o % 8 == 0 || o % 8 == 7))
          chk($sformatf("%s_bit%0d_off%0d", tag, o / 8, o), 32'(tx_s), 32'(exp[o / 8]));
        if (o == last - 1) chk({tag, "_rdy_busy_done_end"}, 32'({ready_s, busy_s, done_s}), 32'b010);
        if (o == last)     chk({tag, "_rdy_busy_done_cpl"}, 32'({ready_s, busy_s, done_s}), 32'b101);
        if (disturb && o == 20) begin
          data         = 8'hC3;
          valid_v[sel] = 1'b1;
        end
        if (disturb && o == 40) valid_v[sel] = 1'b0;
      end
      chk({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    div = 0; baud_run = 1'b1; baud_rose = 1'b0; baud_in = 1'b0;
    reset = 1'b1; data = 8'h00; valid_v = 3'b000; sel = 2'd0;

    // Reset state, then the first cycle after release
    repeat (3) step();
    chk("rst_tx",    32'(w_tx),    32'b111);
    chk("rst_ready", 32'(w_ready), 32'b111);
    chk("rst_busy",  32'(w_busy),  32'b000);
    chk("rst_done",  32'(w_done),  32'b000);
    reset = 1'b0;
    step();
    chk("post_rst_tx",    32'(w_tx),    32'b111);
    chk("post_rst_ready", 32'(w_ready), 32'b111);
    chk("post_rst_done",  32'(w_done),  32'b000);

    // Default framing, 0xA5: 0,1,0,1,0,0,1,0,1,1
    sel = 2'd0;
    send(8'hA5);
    run_frame("def_a5", 16'h034A, 10, 1'b0, waited);
    repeat (5) step();

    // Transfer coinciding with a tick: start bit only after the next tick, 8 clocks later
    for (int i = 0; i < 16 && !baud_rose; i++) step();
    chk("tick_phase_found", 32'(baud_rose), 32'd1);
    send(8'hA5);
    run_frame("algn_a5", 16'h034A, 10, 1'b0, waited);
    chk("algn_start_delay", 32'(waited), 32'd8);

    // Even parity: 0x07 -> parity 1, 0xA5 -> parity 0
    sel = 2'd1;
    send(8'h07);
    run_frame("par_07", 16'h060E, 11, 1'b0, waited);
    send(8'hA5);
    run_frame("par_a5", 16'h054A, 11, 1'b0, waited);

    // Two stop bits, valid held high: second start 2 stop + 1 align periods after first
    sel = 2'd2;
    data = 8'hFF;
    valid_v[2] = 1'b1;
    run_frame("st2_ff1", 16'h07FE, 11, 1'b0, waited);
    valid_v[2] = 1'b0;
    run_frame("st2_ff2", 16'h07FE, 11, 1'b0, waited);
    chk("st2_gap", 32'(waited), 32'd7);

    // Inputs disturbed mid-frame: latched 0x3C goes out, no second frame follows
    sel = 2'd0;
    send(8'h3C);
    run_frame("hold_3c", 16'h0278, 10, 1'b1, waited);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx_s !== 1'b1 || done_s !== 1'b0 || ready_s !== 1'b1) cnt++;
    end
    chk("hold_no_second_frame", 32'(cnt), 32'd0);

    // Reset during data bit 3 of 0x55
    send(8'h55);
    wait_fall("rst_mid", waited, ok);
    repeat (35) step();
    chk("rst_mid_bit3", 32'(tx_s), 32'd0);
    reset = 1'b1;
    step();
    chk("rst_mid_tx_rdy_busy_done", 32'({tx_s, ready_s, busy_s, done_s}), 32'b1100);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (tx_s !== 1'b1 || done_s !== 1'b0) cnt++;
    end
    chk("rst_mid_quiet", 32'(cnt), 32'd0);
    send(8'h55);
    run_frame("rst_55", 16'h02AA, 10, 1'b0, waited);

    // baud_in high through reset release and then frozen: no tick ever
    baud_run = 1'b0;
    baud_in  = 1'b1;
    step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("frz_post_rst", 32'({tx_s, ready_s, busy_s, done_s}), 32'b1100);
    send(8'h5A);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx_s !== 1'b1) cnt++;
    end
    chk("frz_tx_low_cycles", 32'(cnt), 32'd0);
    chk("frz_tx_rdy_busy", 32'({tx_s, ready_s, busy_s}), 32'b101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
